dmem_arbiter: RTL and testbench

- Shares the single-port data memory (DataMem: addr/data/opcode in, out) between two requesters.
  - Port 0 is the CPU load/store path.
  - Port 1 is the debug/DMA loader.
- Sequences each access as ISSUE then RESP, so a store commits on exactly one clock edge and load data is registered back to the winner.
- Arbitration is round-robin by default, with optional fixed priority.

---
 rtl/dmem_arbiter_if.sv | 37 +++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and DataMem.
// The arbiter uses the slave modport; requesters and the memory use master.
interface dmem_arbiter_if;
  logic        req0;
  logic [5:0]  op0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        done0;
  logic [31:0] rdata0;

  logic        req1;
  logic [5:0]  op1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        done1;
  logic [31:0] rdata1;

  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_out;
  logic        busy;

  modport slave (
    input  req0, op0, addr0, wdata0, req1, op1, addr1, wdata1, mem_out,
    output gnt0, done0, rdata0, gnt1, done1, rdata1,
    output mem_addr, mem_data, mem_opcode, busy
  );

  modport master (
    output req0, op0, addr0, wdata0, req1, op1, addr1, wdata1, mem_out,
    input  gnt0, done0, rdata0, gnt1, done1, rdata1,
    input  mem_addr, mem_data, mem_opcode, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: each access runs IDLE -> ISSUE -> RESP,
// so a store commits on exactly one edge and load data is registered back to the winner.
module dmem_arbiter #(
  parameter logic [5:0] OP_NOP     = 6'h00,
  parameter bit         FIXED_PRIO = 1'b0
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]  state_q;
  logic        last_q;
  logic        sel_q;
  logic [5:0]  op_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_data_q;
  logic        gnt0_q, gnt1_q;
  logic        done0_q, done1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        pick;
  logic        op_load;
  logic        op_valid;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  assign op_load  = is_load(op_q);
  assign op_valid = is_load(op_q) | is_store(op_q);

  // On a tie round-robin hands the slot to the port that did not win last time.
  always_comb begin
    pick = bus.req1;
    if (bus.req0 && bus.req1) begin
      pick = FIXED_PRIO ? 1'b0 : ~last_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      op_q       <= OP_NOP;
      mem_addr_q <= 32'h0;
      mem_data_q <= 32'h0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rdata0_q   <= 32'h0;
      rdata1_q   <= 32'h0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            sel_q      <= pick;
            last_q     <= pick;
            op_q       <= pick ? bus.op1 : bus.op0;
            mem_addr_q <= pick ? bus.addr1 : bus.addr0;
            mem_data_q <= pick ? bus.wdata1 : bus.wdata0;
            gnt0_q     <= ~pick;
            gnt1_q     <= pick;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= RESP;
        RESP: begin
          if (sel_q) begin
            rdata1_q <= op_load ? bus.mem_out : 32'h0;
            done1_q  <= 1'b1;
          end else begin
            rdata0_q <= op_load ? bus.mem_out : 32'h0;
            done0_q  <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset overrides the decode so an access cut off mid-ISSUE never writes memory.
  always_comb begin
    bus.mem_opcode = OP_NOP;
    if (!RST) begin
      case (state_q)
        ISSUE:   bus.mem_opcode = op_valid ? op_q : OP_NOP;
        RESP:    bus.mem_opcode = op_load ? op_q : OP_NOP;
        default: bus.mem_opcode = OP_NOP;
      endcase
    end
  end

  assign bus.busy     = (state_q == ISSUE) || (state_q == RESP);
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-addressed DataMem model, transaction-level reference with a
// shadow memory, directed scenarios and a randomized two-port phase.
module tb_dmem_arbiter;
  localparam logic [5:0] NOP = 6'h00;

  logic CLK = 1'b0;
  logic RST;
  logic mem_clr;

  dmem_arbiter_if bus ();
  dmem_arbiter_if fbus ();

  dmem_arbiter #(.OP_NOP(NOP), .FIXED_PRIO(1'b0)) u_dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
  dmem_arbiter #(.OP_NOP(NOP), .FIXED_PRIO(1'b1)) u_fix (.CLK(CLK), .RST(RST), .bus(fbus.slave));

  always #5 CLK = ~CLK;

  assign fbus.mem_out = 32'h0;

  // DataMem model: little-endian bytes, combinational read formatted by opcode.
  logic [7:0]  mem [256];
  logic [7:0]  dm_base;
  logic [31:0] dm_word;
  logic [7:0]  dm_byte;
  logic [15:0] dm_half;

  always_comb begin
    dm_base = {bus.mem_addr[7:2], 2'b00};
    dm_word = {mem[dm_base + 8'd3], mem[dm_base + 8'd2], mem[dm_base + 8'd1], mem[dm_base]};
    dm_byte = 8'(dm_word >> {bus.mem_addr[1:0], 3'b000});
    dm_half = bus.mem_addr[1] ? dm_word[31:16] : dm_word[15:0];
    case (bus.mem_opcode)
      6'h20:   bus.mem_out = {{24{dm_byte[7]}}, dm_byte};
      6'h24:   bus.mem_out = {24'h0, dm_byte};
      6'h21:   bus.mem_out = {{16{dm_half[15]}}, dm_half};
      6'h25:   bus.mem_out = {16'h0, dm_half};
      default: bus.mem_out = dm_word;
    endcase
  end

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7);
    end else begin
      case (bus.mem_opcode)
        6'h28: mem[bus.mem_addr[7:0]] <= bus.mem_data[7:0];
        6'h29: begin
          mem[{bus.mem_addr[7:1], 1'b0}] <= bus.mem_data[7:0];
          mem[{bus.mem_addr[7:1], 1'b1}] <= bus.mem_data[15:8];
        end
        6'h2B: begin
          mem[{bus.mem_addr[7:2], 2'd0}] <= bus.mem_data[7:0];
          mem[{bus.mem_addr[7:2], 2'd1}] <= bus.mem_data[15:8];
          mem[{bus.mem_addr[7:2], 2'd2}] <= bus.mem_data[23:16];
          mem[{bus.mem_addr[7:2], 2'd3}] <= bus.mem_data[31:24];
        end
        default: ;
      endcase
    end
  end

  int vecs = 0;
  int errs = 0;

  // Reference model state: one access in flight at most, shadow memory updated at completion.
  logic [7:0]  sh [256];
  bit          txn;
  int          age;
  int          m_port;
  bit          m_last;
  logic [5:0]  m_op;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] e_rd [2];
  logic [31:0] e_ma, e_md;
  int          n_act, n_sw;

  function automatic bit is_ld(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
    logic [7:0] a, h, w;
    a = addr[7:0];
    h = a & 8'hFE;
    w = a & 8'hFC;
    case (op)
      6'h20:   return {{24{sh[a][7]}}, sh[a]};
      6'h24:   return {24'h0, sh[a]};
      6'h21:   return {{16{sh[h + 8'd1][7]}}, sh[h + 8'd1], sh[h]};
      6'h25:   return {16'h0, sh[h + 8'd1], sh[h]};
      default: return {sh[w + 8'd3], sh[w + 8'd2], sh[w + 8'd1], sh[w]};
    endcase
  endfunction

  task automatic ref_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d);
    logic [7:0] a;
    a = addr[7:0];
    case (op)
      6'h28: sh[a] = d[7:0];
      6'h29: begin
        a = a & 8'hFE;
        sh[a] = d[7:0];
        sh[a + 8'd1] = d[15:8];
      end
      default: begin
        a = a & 8'hFC;
        for (int i = 0; i < 4; i++) sh[a + 8'(i)] = 8'(d >> (8 * i));
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict from the current inputs, then compare every output.
  task automatic tick();
    logic [1:0] eg, ed;
    logic [5:0] eop;
    eg = 2'b00;
    ed = 2'b00;
    if (RST) begin
      txn = 0;
      m_last = 1;
      e_rd[0] = 32'h0;
      e_rd[1] = 32'h0;
      e_ma = 32'h0;
      e_md = 32'h0;
    end else if (txn) begin
      age++;
      if (age == 3) begin
        txn = 0;
        ed[m_port] = 1'b1;
        e_rd[m_port] = is_ld(m_op) ? ref_load(m_op, m_addr) : 32'h0;
        if (is_st(m_op)) ref_store(m_op, m_addr, m_wdata);
      end
    end else if (bus.req0 || bus.req1) begin
      m_port  = (bus.req0 && bus.req1) ? (m_last ? 0 : 1) : (bus.req1 ? 1 : 0);
      m_last  = (m_port == 1);
      m_op    = m_port ? bus.op1 : bus.op0;
      m_addr  = m_port ? bus.addr1 : bus.addr0;
      m_wdata = m_port ? bus.wdata1 : bus.wdata0;
      e_ma = m_addr;
      e_md = m_wdata;
      txn = 1;
      age = 1;
      eg[m_port] = 1'b1;
    end
    eop = NOP;
    if (txn && age == 1 && (is_ld(m_op) || is_st(m_op))) eop = m_op;
    if (txn && age == 2 && is_ld(m_op)) eop = m_op;
    @(posedge CLK);
    #1;
    if (bus.mem_opcode != NOP) n_act++;
    if (bus.mem_opcode == 6'h2B) n_sw++;
    chk("gnt0", 32'(bus.gnt0), 32'(eg[0]));
    chk("gnt1", 32'(bus.gnt1), 32'(eg[1]));
    chk("done0", 32'(bus.done0), 32'(ed[0]));
    chk("done1", 32'(bus.done1), 32'(ed[1]));
    chk("rdata0", bus.rdata0, e_rd[0]);
    chk("rdata1", bus.rdata1, e_rd[1]);
    chk("busy", 32'(bus.busy), 32'(txn));
    chk("mem_opcode", 32'(bus.mem_opcode), 32'(eop));
    chk("mem_addr", bus.mem_addr, e_ma);
    chk("mem_data", bus.mem_data, e_md);
  endtask

  task automatic drive(input int p, input logic r, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd);
    if (p == 0) begin
      bus.req0 = r; bus.op0 = op; bus.addr0 = a; bus.wdata0 = wd;
    end else begin
      bus.req1 = r; bus.op1 = op; bus.addr1 = a; bus.wdata1 = wd;
    end
  endtask

  // One complete access on port p; returns cycles from request to gnt and to done (-1 = never).
  task automatic issue(input int p, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd, output int glat, output int dlat);
    glat = -1;
    dlat = -1;
    drive(p, 1'b1, op, a, wd);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (glat < 0 && ((p == 0) ? bus.gnt0 : bus.gnt1)) begin
        glat = i;
        drive(p, 1'b0, 6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
      if ((p == 0) ? bus.done0 : bus.done1) begin
        dlat = i;
        break;
      end
    end
    drive(p, 1'b0, NOP, 32'h0, 32'h0);
  endtask

  logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F, 6'h00};

  initial begin
    int gl, dl, lat, ng0, ng1;
    int gq[$];
    int tq[$];
    bit pend[2];
    logic [5:0] rop;
    logic [31:0] ra;

    RST = 1'b1;
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) sh[i] = 8'(i * 7);
    drive(0, 1'b0, NOP, 32'h0, 32'h0);
    drive(1, 1'b0, NOP, 32'h0, 32'h0);
    fbus.req0 = 1'b0; fbus.op0 = 6'h23; fbus.addr0 = 32'h0; fbus.wdata0 = 32'h0;
    fbus.req1 = 1'b0; fbus.op1 = 6'h23; fbus.addr1 = 32'h4; fbus.wdata1 = 32'h0;
    txn = 0;
    tick();
    tick();
    RST = 1'b0;
    mem_clr = 1'b0;
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_opcode", 32'(bus.mem_opcode), 32'(NOP));

    // sw then lw on port 0
    n_sw = 0;
    issue(0, 6'h2B, 32'h10, 32'hDEAD_BEEF, gl, dl);
    chk("sw_gnt_lat", gl, 1);
    chk("sw_done_lat", dl, 3);
    chk("sw_one_cycle", n_sw, 1);
    issue(0, 6'h23, 32'h10, 32'h0, gl, dl);
    chk("lw_done_lat", dl, 3);
    chk("lw_rdata0", bus.rdata0, 32'hDEAD_BEEF);

    // Both ports request together and hold: round-robin from port 0
    RST = 1'b1;
    tick();
    RST = 1'b0;
    drive(0, 1'b1, 6'h23, 32'h10, 32'h0);
    drive(1, 1'b1, 6'h23, 32'h14, 32'h0);
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (bus.gnt0) begin gq.push_back(0); tq.push_back(i); end
      if (bus.gnt1) begin gq.push_back(1); tq.push_back(i); end
    end
    drive(0, 1'b0, NOP, 32'h0, 32'h0);
    drive(1, 1'b0, NOP, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("rr_count", 32'(gq.size() >= 4), 32'h1);
    if (gq.size() >= 4) begin
      chk("rr_g0", gq[0], 0);
      chk("rr_g1", gq[1], 1);
      chk("rr_g2", gq[2], 0);
      chk("rr_g3", gq[3], 1);
      chk("rr_first", tq[0], 1);
      chk("rr_space", tq[3] - tq[0], 9);
    end

    // Invalid opcode on port 1: no memory traffic, zero data
    n_act = 0;
    issue(1, 6'h3F, 32'h10, 32'h5555_5555, gl, dl);
    chk("inv_done_lat", dl, 3);
    chk("inv_no_access", n_act, 0);
    chk("inv_rdata1", bus.rdata1, 32'h0);
    issue(1, 6'h23, 32'h10, 32'h0, gl, dl);
    chk("inv_mem_kept", bus.rdata1, 32'hDEAD_BEEF);
    chk("rdata0_kept", bus.rdata0, 32'hDEAD_BEEF);

    // Reset during ISSUE of a store
    issue(0, 6'h2B, 32'h20, 32'hCAFE_F00D, gl, dl);
    drive(0, 1'b1, 6'h2B, 32'h20, 32'h1234_5678);
    tick();
    chk("rst_in_issue", 32'(bus.gnt0), 32'h1);
    RST = 1'b1;
    drive(0, 1'b0, NOP, 32'h0, 32'h0);
    #1;
    chk("rst_opcode_nop", 32'(bus.mem_opcode), 32'(NOP));
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    issue(0, 6'h23, 32'h20, 32'h0, gl, dl);
    chk("rst_no_commit", bus.rdata0, 32'hCAFE_F00D);

    // Byte stores and loads
    issue(0, 6'h2B, 32'h20, 32'h0, gl, dl);
    issue(0, 6'h28, 32'h21, 32'hAB, gl, dl);
    issue(0, 6'h24, 32'h21, 32'h0, gl, dl);
    chk("lbu", bus.rdata0, 32'h0000_00AB);
    issue(1, 6'h28, 32'h22, 32'h80, gl, dl);
    issue(1, 6'h20, 32'h22, 32'h0, gl, dl);
    chk("lb_sext", bus.rdata1, 32'hFFFF_FF80);

    // Fixed priority instance: port 1 starved while port 0 holds its request
    ng0 = 0;
    ng1 = 0;
    fbus.req0 = 1'b1;
    fbus.req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fbus.gnt0) ng0++;
      if (fbus.gnt1) ng1++;
    end
    chk("fix_no_gnt1", ng1, 0);
    chk("fix_gnt0", ng0, 4);
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fbus.gnt1) ng1++;
      if (fbus.gnt0) begin
        fbus.req0 = 1'b0;
        break;
      end
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (fbus.gnt1) begin
        lat = i;
        break;
      end
    end
    chk("fix_gnt1_late", 32'(lat >= 1 && lat <= 3), 32'h1);
    chk("fix_starved", ng1, 0);
    fbus.req1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic on both ports
    pend[0] = 0;
    pend[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && ((p == 0) ? bus.gnt0 : bus.gnt1)) pend[p] = 0;
        if (!pend[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            rop = ops[$urandom_range(0, 9)];
            ra = 32'($urandom_range(0, 255));
            if (rop inside {6'h21, 6'h25, 6'h29}) ra[0] = 1'b0;
            if (rop inside {6'h23, 6'h2B}) ra[1:0] = 2'b00;
            drive(p, 1'b1, rop, ra, $urandom);
            pend[p] = 1;
          end else begin
            drive(p, 1'b0, 6'($urandom), $urandom, $urandom);
          end
        end
      end
      tick();
    end
    drive(0, 1'b0, NOP, 32'h0, 32'h0);
    drive(1, 1'b0, NOP, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
